// File: rtl/netbus_pkg.sv
// Shared NetBus definitions: word width helper and default queue depth.
package netbus_pkg;

    localparam int NETBUS_DEFAULT_DEPTH = 16;

    function automatic int netbus_word_w(input int data_width);
        return data_width * 9 + 14;
    endfunction

endpackage

// File: rtl/netbus_tx_queue_if.sv
// VALID/READY bus between the local frame source, the tx queue and the fan-out.
interface netbus_tx_queue_if #(
    parameter int W  = 50,
    parameter int LW = 5
);
    logic [W-1:0]  in_data;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  out_data;
    logic          out_valid;
    logic          out_ready;
    logic [LW-1:0] level;
    logic          stall_drop;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, level, stall_drop
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, level, stall_drop
    );
endinterface

// File: rtl/netbus_txq_ram.sv
// Queue storage: synchronous write, asynchronous read for first-word fall-through.
module netbus_txq_ram #(
    parameter int W     = 50,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [W-1:0]  i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [W-1:0]  o_rdata
);
    logic [W-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/netbus_tx_queue.sv
// Elastic tx queue in front of the NetBus fan-out.
// Define NETBUS_TXQ_TIMEOUT_EN to discard a head word stalled for TIMEOUT cycles.
module netbus_tx_queue
    import netbus_pkg::*;
#(
    parameter int DATA_WIDTH = 4,
    parameter int DEPTH      = NETBUS_DEFAULT_DEPTH,
    parameter int TIMEOUT    = 255
) (
    input  logic             i_clk,
    input  logic             i_rst,
    netbus_tx_queue_if.slave bus
);
    localparam int W  = netbus_word_w(DATA_WIDTH);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH) + 1;
    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("netbus_tx_queue: DEPTH must be a power of two >= 2");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("netbus_tx_queue: TIMEOUT must be >= 1");
    end

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [LW-1:0] r_level;
    logic          w_in_ready;
    logic          w_out_valid;
    logic          w_wr;
    logic          w_rd;
    logic          w_drop;
    logic          w_pop;
    logic [W-1:0]  w_rdata;

    // Ready comes from registered level only, so a read never frees a slot in the same cycle.
    assign w_in_ready  = !i_rst && (r_level != FULL_LEVEL);
    assign w_out_valid = (r_level != '0);
    assign w_wr        = bus.in_valid && w_in_ready;
    assign w_rd        = w_out_valid && bus.out_ready;
    assign w_pop       = w_rd || w_drop;

    netbus_txq_ram #(
        .W     (W),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .i_clk   (i_clk),
        .i_we    (w_wr),
        .i_waddr (r_wr_ptr),
        .i_wdata (bus.in_data),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_wr && !w_pop) begin
                r_level <= r_level + 1'b1;
            end else if (!w_wr && w_pop) begin
                r_level <= r_level - 1'b1;
            end
        end
    end

`ifdef NETBUS_TXQ_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] r_stall_cnt;

    // Drop fires during the TIMEOUT-th consecutive stalled cycle of the current head.
    assign w_drop = w_out_valid && !bus.out_ready && (r_stall_cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst || !w_out_valid || w_rd || w_drop) begin
            r_stall_cnt <= '0;
        end else begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end
`else
    assign w_drop = 1'b0;
`endif

    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = w_out_valid;
    assign bus.out_data   = w_rdata;
    assign bus.level      = r_level;
    assign bus.stall_drop = w_drop;
endmodule

// File: tb/tb_netbus_tx_queue.sv
// Scoreboard bench for netbus_tx_queue; a second instance with TIMEOUT=8 covers the stall drop.
module tb_netbus_tx_queue;
    import netbus_pkg::*;

    localparam int W  = netbus_word_w(4);
    localparam int LW = 5;

    logic clk;
    logic rst;

    netbus_tx_queue_if #(.W(W), .LW(LW)) q_if ();
    netbus_tx_queue_if #(.W(W), .LW(LW)) t_if ();

    netbus_tx_queue #(.DATA_WIDTH(4), .DEPTH(16), .TIMEOUT(255)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (q_if)
    );

    netbus_tx_queue #(.DATA_WIDTH(4), .DEPTH(16), .TIMEOUT(8)) dut_to (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (t_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    logic [W-1:0] exp_q [$];
    logic         t_drop_s;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    // One clock: sample handshakes before the edge, then score pops and pushes after it.
    task automatic cycle();
        logic fw, fr, rs;
        logic [W-1:0] din, dout, exp_w;
        #1;
        fw       = q_if.in_valid && q_if.in_ready;
        fr       = q_if.out_valid && q_if.out_ready;
        din      = q_if.in_data;
        dout     = q_if.out_data;
        rs       = rst;
        t_drop_s = t_if.stall_drop;
        @(posedge clk);
        #1;
        if (rs) begin
            exp_q.delete();
        end else begin
            if (fr) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_underflow: got word %h, required no output", dout);
                end else begin
                    exp_w = exp_q.pop_front();
                    if (dout !== exp_w) begin
                        n_fail++;
                        $display("FAIL sb_order: got %h, required %h", dout, exp_w);
                    end
                end
            end
            if (fw) exp_q.push_back(din);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cycle();
        cycle();
        n_tests++;
        if (q_if.level !== 5'd0 || q_if.out_valid !== 1'b0 || q_if.in_ready !== 1'b0 || q_if.stall_drop !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: got level=%0d ov=%b ir=%b sd=%b, required 0 0 0 0",
                     q_if.level, q_if.out_valid, q_if.in_ready, q_if.stall_drop);
        end
        rst = 1'b0;
        #1;
        n_tests++;
        if (q_if.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ready: got %b, required 1", q_if.in_ready);
        end
    endtask

    task automatic test_first_word();
        q_if.in_data  = W'(1);
        q_if.in_valid = 1'b1;
        cycle();
        q_if.in_valid = 1'b0;
        n_tests++;
        if (q_if.out_valid !== 1'b1 || q_if.out_data !== W'(1) || q_if.level !== 5'd1) begin
            n_fail++;
            $display("FAIL first_word: got ov=%b data=%h level=%0d, required 1 %h 1",
                     q_if.out_valid, q_if.out_data, q_if.level, W'(1));
        end
        q_if.out_ready = 1'b1;
        cycle();
        q_if.out_ready = 1'b0;
    endtask

    task automatic fill(input int n, input int base);
        q_if.out_ready = 1'b0;
        for (int i = 0; i < n; i++) begin
            q_if.in_data  = W'(base + i);
            q_if.in_valid = 1'b1;
            cycle();
        end
        q_if.in_valid = 1'b0;
    endtask

    task automatic drain(input int n);
        q_if.in_valid  = 1'b0;
        q_if.out_ready = 1'b1;
        for (int i = 0; i < n; i++) cycle();
        q_if.out_ready = 1'b0;
    endtask

    task automatic test_fill_drain();
        fill(16, 0);
        n_tests++;
        if (q_if.level !== 5'd16 || q_if.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL full_state: got level=%0d ir=%b, required 16 0", q_if.level, q_if.in_ready);
        end
        drain(16);
        n_tests++;
        if (q_if.level !== 5'd0 || q_if.out_valid !== 1'b0 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drained: got level=%0d ov=%b pending=%0d, required 0 0 0",
                     q_if.level, q_if.out_valid, exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        int bad;
        bad = 0;
        fill(5, 'h100);
        q_if.in_valid  = 1'b1;
        q_if.out_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            q_if.in_data = W'('h200 + i);
            cycle();
            if (q_if.level !== 5'd5) bad++;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL streaming_level: got %0d cycles with level!=5, required 0", bad);
        end
        drain(5);
        n_tests++;
        if (q_if.level !== 5'd0) begin
            n_fail++;
            $display("FAIL streaming_drain: got level=%0d, required 0", q_if.level);
        end
    endtask

    task automatic test_full_rw();
        fill(16, 'h300);
        q_if.in_data   = W'('hABC);
        q_if.in_valid  = 1'b1;
        q_if.out_ready = 1'b1;
        cycle();
        q_if.in_valid  = 1'b0;
        q_if.out_ready = 1'b0;
        n_tests++;
        if (q_if.level !== 5'd15 || q_if.out_data !== W'('h301)) begin
            n_fail++;
            $display("FAIL full_rw: got level=%0d head=%h, required 15 %h", q_if.level, q_if.out_data, W'('h301));
        end
        drain(15);
        n_tests++;
        if (q_if.level !== 5'd0 || q_if.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL full_rw_drain: got level=%0d ov=%b, required 0 0", q_if.level, q_if.out_valid);
        end
    endtask

    task automatic test_reset_mid();
        fill(7, 'h400);
        n_tests++;
        if (q_if.level !== 5'd7) begin
            n_fail++;
            $display("FAIL mid_fill: got level=%0d, required 7", q_if.level);
        end
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        n_tests++;
        if (q_if.level !== 5'd0 || q_if.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset: got level=%0d ov=%b, required 0 0", q_if.level, q_if.out_valid);
        end
        q_if.in_data  = W'('h55);
        q_if.in_valid = 1'b1;
        cycle();
        q_if.in_valid = 1'b0;
        n_tests++;
        if (q_if.out_valid !== 1'b1 || q_if.out_data !== W'('h55) || q_if.level !== 5'd1) begin
            n_fail++;
            $display("FAIL post_reset_head: got ov=%b data=%h level=%0d, required 1 %h 1",
                     q_if.out_valid, q_if.out_data, q_if.level, W'('h55));
        end
        drain(1);
    endtask

    task automatic test_timeout();
        int pulses, first_idx;
        pulses    = 0;
        first_idx = 0;
        t_if.out_ready = 1'b0;
        t_if.in_valid  = 1'b1;
        t_if.in_data   = W'('h11);
        cycle();
        t_if.in_data   = W'('h22);
        cycle();
        t_if.in_valid  = 1'b0;
        if (t_drop_s === 1'b1) pulses++;
        // Stall cycle 1 was the second write cycle; observe stall cycles 2..13.
        for (int idx = 2; idx <= 13; idx++) begin
            cycle();
            if (t_drop_s === 1'b1) begin
                pulses++;
                if (first_idx == 0) first_idx = idx;
            end
        end
`ifdef NETBUS_TXQ_TIMEOUT_EN
        n_tests++;
        if (pulses != 1 || first_idx != 8) begin
            n_fail++;
            $display("FAIL stall_drop_pulse: got %0d pulses first at stall %0d, required 1 at 8", pulses, first_idx);
        end
        n_tests++;
        if (t_if.level !== 5'd1 || t_if.out_data !== W'('h22)) begin
            n_fail++;
            $display("FAIL stall_drop_head: got level=%0d head=%h, required 1 %h", t_if.level, t_if.out_data, W'('h22));
        end
`else
        n_tests++;
        if (pulses != 0) begin
            n_fail++;
            $display("FAIL stall_hold_pulse: got %0d pulses, required 0", pulses);
        end
        n_tests++;
        if (t_if.level !== 5'd2 || t_if.out_data !== W'('h11)) begin
            n_fail++;
            $display("FAIL stall_hold_head: got level=%0d head=%h, required 2 %h", t_if.level, t_if.out_data, W'('h11));
        end
`endif
        t_if.out_ready = 1'b1;
        cycle();
        cycle();
        t_if.out_ready = 1'b0;
        n_tests++;
        if (t_if.level !== 5'd0) begin
            n_fail++;
            $display("FAIL stall_cleanup: got level=%0d, required 0", t_if.level);
        end
    endtask

    initial begin
        rst            = 1'b1;
        q_if.in_data   = '0;
        q_if.in_valid  = 1'b0;
        q_if.out_ready = 1'b0;
        t_if.in_data   = '0;
        t_if.in_valid  = 1'b0;
        t_if.out_ready = 1'b0;
        test_reset();
        test_first_word();
        test_fill_drain();
        test_back_to_back();
        test_full_rw();
        test_reset_mid();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
